// File: rtl/fft_r2_ctrl_if.sv
// Handshake and memory-addressing bundle between the FFT sequencer and its
// start/butterfly/memory peers. The master modport is the sequencer side.
// The optional unload port pair exists only when FFT_CTRL_BITREV_UNLOAD_EN is defined.
interface fft_r2_ctrl_if #(
  parameter int ADDR_WIDTH = 3
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] stage;
  logic                  bf_valid;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [ADDR_WIDTH-2:0] tw_addr;
  logic [ADDR_WIDTH-2:0] tag_out;
  logic [ADDR_WIDTH-2:0] tag_in;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr_a;
  logic [ADDR_WIDTH-1:0] wr_addr_b;
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
`endif

  modport master (
    input  start, tag_in,
    output busy, done, stage, bf_valid, rd_addr_a, rd_addr_b, tw_addr,
           tag_out, wr_en, wr_addr_a, wr_addr_b
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
  , output out_valid, out_addr
`endif
  );

  modport slave (
    output start, tag_in,
    input  busy, done, stage, bf_valid, rd_addr_a, rd_addr_b, tw_addr,
           tag_out, wr_en, wr_addr_a, wr_addr_b
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
  , input  out_valid, out_addr
`endif
  );
endinterface

// File: rtl/fft_r2_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues N/2 butterflies per stage,
// maps returned tags to write-back addresses and drains the butterfly
// pipeline between stages. Optional natural-order readout sweep is enabled
// by defining FFT_CTRL_BITREV_UNLOAD_EN.
module fft_r2_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int PIPE_LAT   = 3
) (
  input  logic           clk,
  input  logic           rst,
  fft_r2_ctrl_if.master  bus
);
  localparam int AW = ADDR_WIDTH;
  localparam int TW = ADDR_WIDTH - 1;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
  , UNLOAD
`endif
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   j_q;
  logic [AW-1:0]   stage_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            bf_valid_q;
  logic [AW-1:0]   rd_a_q;
  logic [AW-1:0]   rd_b_q;
  logic [TW-1:0]   tw_q;
  logic [TW-1:0]   tag_q;
  logic [PIPE_LAT-1:0] dl_q;
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
  logic [AW-1:0]   k_q;
  logic            out_valid_q;
  logic [AW-1:0]   out_addr_q;
`endif

  logic            iss_en;
  logic [TW-1:0]   iss_j;
  logic [AW-1:0]   iss_s;
  logic [AW-1:0]   iss_a;
  logic [AW-1:0]   iss_b;
  logic [TW-1:0]   iss_tw;
  logic            drain_last;
  logic            stage_last;
  logic            wr_en;
  logic [AW-1:0]   wr_a;
  logic [AW-1:0]   wr_b;

  // Upper-leg address: insert a zero at bit s of j (grp*2*half + pos).
  function automatic logic [AW-1:0] pair_a(input logic [TW-1:0] j, input logic [AW-1:0] s);
    logic [AW-1:0] jw;
    logic [AW-1:0] mask;
    jw   = {1'b0, j};
    mask = (AW'(1) << s) - AW'(1);
    return ((jw & ~mask) << 1) | (jw & mask);
  endfunction

  // Twiddle index: pos << (L-1-s); pos always fits in TW bits since s <= L-1.
  function automatic logic [TW-1:0] tw_idx(input logic [TW-1:0] j, input logic [AW-1:0] s);
    logic [TW-1:0] m;
    m = (TW'(1) << s) - TW'(1);
    return (j & m) << (AW'(AW - 1) - s);
  endfunction

`ifdef FFT_CTRL_BITREV_UNLOAD_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] k);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) r[i] = k[AW-1-i];
    return r;
  endfunction
`endif

  assign drain_last = (cnt_q == CW'(PIPE_LAT - 1));
  assign stage_last = (stage_q == AW'(AW - 1));

  // Decide whether a butterfly is issued at the coming edge, and which one.
  always_comb begin
    iss_en = 1'b0;
    iss_j  = j_q + TW'(1);
    iss_s  = stage_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          iss_en = 1'b1;
          iss_j  = '0;
          iss_s  = '0;
        end
      end
      RUN: begin
        if (j_q != '1) iss_en = 1'b1;
      end
      DRAIN: begin
        if (drain_last && !stage_last) begin
          iss_en = 1'b1;
          iss_j  = '0;
          iss_s  = stage_q + AW'(1);
        end
      end
      default: ;
    endcase
    iss_a  = pair_a(iss_j, iss_s);
    iss_b  = iss_a | (AW'(1) << iss_s);
    iss_tw = tw_idx(iss_j, iss_s);
  end

  // Sequencer FSM with registered issue and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      j_q        <= '0;
      stage_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bf_valid_q <= 1'b0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      tw_q       <= '0;
      tag_q      <= '0;
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
`endif
    end else begin
      bf_valid_q <= iss_en;
      rd_a_q     <= iss_en ? iss_a  : '0;
      rd_b_q     <= iss_en ? iss_b  : '0;
      tw_q       <= iss_en ? iss_tw : '0;
      tag_q      <= iss_en ? iss_j  : '0;
      if (iss_en) begin
        j_q     <= iss_j;
        stage_q <= iss_s;
      end
      done_q <= 1'b0;
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (j_q == '1) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          if (!drain_last) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (!stage_last) begin
            state_q <= RUN;
          end else begin
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
            state_q     <= UNLOAD;
            k_q         <= '0;
            out_valid_q <= 1'b1;
            out_addr_q  <= '0;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
        UNLOAD: begin
          if (k_q == '1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            k_q         <= k_q + AW'(1);
            out_valid_q <= 1'b1;
            out_addr_q  <= bitrev(k_q + AW'(1));
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Issue strobe delayed by the read+butterfly latency gives the write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q <= '0;
    end else begin
      dl_q[0] <= bf_valid_q;
      for (int unsigned i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign wr_en = dl_q[PIPE_LAT-1];

  // Write-back addresses from the returned tag; gated by wr_en so they read
  // zero whenever no write is pending (including right after reset).
  always_comb begin
    wr_a = '0;
    wr_b = '0;
    if (wr_en) begin
      wr_a = pair_a(bus.tag_in, stage_q);
      wr_b = wr_a | (AW'(1) << stage_q);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.bf_valid  = bf_valid_q;
  assign bus.rd_addr_a = rd_a_q;
  assign bus.rd_addr_b = rd_b_q;
  assign bus.tw_addr   = tw_q;
  assign bus.tag_out   = tag_q;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr_a = wr_a;
  assign bus.wr_addr_b = wr_b;
`ifdef FFT_CTRL_BITREV_UNLOAD_EN
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
`endif
endmodule
